sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM macro between the multi-cycle CPU's instruction-fetch port (read-only) and its data port (read/write, byte enables).
- Arbitrates requests, drives the macro's CSN/WEN/ADDR/BE/DI pins, and returns read data from DOUT.
- Read data comes back one cycle after the grant.
- Sits between the CPU core and the unified memory macro.

Parameters:
- AWIDTH, 12: word-address width, matches the SRAM ADDR width.
- DWIDTH, 32: data width; fixed 32, byte-enable width = DWIDTH/8.

Ports:
- CLK  in  1  rising-edge clock, shared with the SRAM.
- RST  in  1  synchronous active-high reset.
- I_REQ  in  1  instruction read request.
- I_ADDR  in  AWIDTH  instruction word address.
- I_GNT  out  1  I request accepted this cycle.
- I_RVALID  out  1  I_RDATA valid.
- I_RDATA  out  DWIDTH  instruction word.
- D_REQ  in  1  data request.
- D_WE  in  1  1=write, 0=read.
- D_BE  in  4  write byte enables.
- D_ADDR  in  AWIDTH  data word address.
- D_WDATA  in  DWIDTH  write data.
- D_GNT  out  1  D request accepted this cycle.
- D_RVALID  out  1  response: read data valid, or write-complete ack.
- D_RDATA  out  DWIDTH  read data; 0 for write acks.
- M_CSN  out  1  SRAM chip select, active low.
- M_WEN  out  1  SRAM write enable, active low.
- M_ADDR  out  AWIDTH  SRAM address.
- M_BE  out  4  SRAM byte enables.
- M_DI  out  DWIDTH  SRAM write data.
- M_DOUT  in  DWIDTH  SRAM read data, registered inside the macro, valid after the edge.

Behaviour:
- Requester rule: REQ and all qualifiers stay stable until GNT is seen high. REQ may deassert only after GNT.
- Arbitration: combinational, each cycle. At most one GNT is high.
- Default policy is fixed priority: D over I.
- Issue cycle N (GNT=1):
  - M_CSN=0.
  - M_WEN=~D_WE for D; M_WEN=1 for I.
  - M_ADDR and M_BE from the winner. I reads drive M_BE=4'hF.
  - M_DI=D_WDATA for D; 0 for I.
- No grant: M_CSN=1, M_WEN=1, M_ADDR/M_BE/M_DI hold 0.
- Response register: rsp_owner = {NONE, I_RD, D_RD, D_WR}, loaded at the end of every cycle (NONE if no grant).
- Cycle N+1 by rsp_owner:
  - I_RD: I_RVALID=1, I_RDATA=M_DOUT.
  - D_RD: D_RVALID=1, D_RDATA=M_DOUT.
  - D_WR: D_RVALID=1, D_RDATA=0.
  - RDATA outputs are 0 whenever their RVALID is 0.
- Latency and throughput: fixed 1-cycle latency, one access per cycle fully pipelined. A new grant may issue in the same cycle as the previous response.
- Read-after-write to the same address on consecutive grants returns the newly written bytes. The macro's write updates the array at the issue edge.
- Reset (RST high, sampled at the edge):
  - rsp_owner=NONE, priority pointer=D.
  - While RST is high, the GNTs are forced 0 and M_CSN=1.
  - All RVALIDs are 0 in the cycle after reset is sampled.
  - Reset mid-operation drops any in-flight response. No RVALID follows for the dropped access, and the requester re-requests.
- D_WE=1 with D_BE=0: granted and acked, memory unchanged.
- Address wrap-around is not handled here: the address passes through unmodified.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer names the preferred requester and flips to the other requester after each grant. When both request continuously, grants alternate D, I, D, I.
- Undefined: fixed priority, D wins. I can starve while D_REQ stays high.

Decomposition:
- Shared package sram_arb_pkg:
  - AWIDTH/DWIDTH defaults.
  - rsp_owner enum encoding: NONE=2'd0, I_RD=2'd1, D_RD=2'd2, D_WR=2'd3.
  - Requester id constants REQ_I=1'b0, REQ_D=1'b1.
- One sub-module, sram_arb_pick: combinational picker taking req_i, req_d and the pointer, returning gnt_i and gnt_d. The pointer is ignored unless ARB_RR_EN is defined.
- The top module holds the response register, the pointer and the SRAM pin muxing.

Test Plan:
- Preload mem[5]=32'hDEADBEEF. I_REQ=1, I_ADDR=5 for one cycle → I_GNT=1 that cycle; next cycle I_RVALID=1, I_RDATA=32'hDEADBEEF.
- D write addr 9, D_WDATA=32'h11223344, D_BE=4'b0101 over old 32'hAABBCCDD → D_RVALID ack next cycle. A following D read of addr 9 returns 32'hAA22CC44.
- I_REQ and D_REQ both high for 4 cycles with different addresses:
  - Fixed priority: D granted all 4 cycles, I_GNT=0.
  - ARB_RR_EN: grants alternate D, I, D, I and each RVALID follows its grant by 1 cycle.
- Back-to-back D reads of addrs 1, 2, 3 on consecutive cycles → D_RVALID high 3 consecutive cycles with mem[1], mem[2], mem[3] in order.
- Assert RST in the cycle after an I grant → no I_RVALID follows, M_CSN=1, both GNTs are 0 while RST is high. After release, a new request is granted normally.
- Idle, no REQ → M_CSN stays 1, no RVALID, and SRAM contents are unchanged.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the instruction/data SRAM port arbiter.
package sram_arb_pkg;
  localparam int AWIDTH_DEF = 12;
  localparam int DWIDTH_DEF = 32;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_I_RD = 2'd1,
    RSP_D_RD = 2'd2,
    RSP_D_WR = 2'd3
  } rsp_owner_t;
endpackage

// File: rtl/sram_arb_pick.sv
// Combinational I/D grant picker; round-robin on the pointer when ARB_RR_EN
// is defined, otherwise fixed priority with D winning.
import sram_arb_pkg::*;

module sram_arb_pick (
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_ptr,
  output logic o_gnt_i,
  output logic o_gnt_d
);
`ifdef ARB_RR_EN
  // Pointer only matters on contention; a lone requester always wins.
  assign o_gnt_d = i_req_d & (~i_req_i | (i_ptr == REQ_D));
  assign o_gnt_i = i_req_i & ~o_gnt_d;
`else
  logic w_unused_ptr;
  assign w_unused_ptr = i_ptr;
  assign o_gnt_d = i_req_d;
  assign o_gnt_i = i_req_i & ~i_req_d;
`endif
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the I-fetch and data ports with a fixed
// 1-cycle response; ARB_RR_EN selects round-robin instead of D-first priority.
import sram_arb_pkg::*;

module sram_port_arbiter #(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [AWIDTH-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [DWIDTH-1:0] I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [DWIDTH/8-1:0] D_BE,
  input  logic [AWIDTH-1:0] D_ADDR,
  input  logic [DWIDTH-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DWIDTH-1:0] D_RDATA,
  output logic              M_CSN,
  output logic              M_WEN,
  output logic [AWIDTH-1:0] M_ADDR,
  output logic [DWIDTH/8-1:0] M_BE,
  output logic [DWIDTH-1:0] M_DI,
  input  logic [DWIDTH-1:0] M_DOUT
);
  localparam int BEW = DWIDTH / 8;

  rsp_owner_t r_rsp, w_rsp_nxt;
  logic       r_ptr;
  logic       w_gnt_i, w_gnt_d;

  sram_arb_pick u_pick (
    .i_req_i (I_REQ & ~RST),
    .i_req_d (D_REQ & ~RST),
    .i_ptr   (r_ptr),
    .o_gnt_i (w_gnt_i),
    .o_gnt_d (w_gnt_d)
  );

  assign I_GNT = w_gnt_i;
  assign D_GNT = w_gnt_d;

  always_comb begin
    M_CSN     = 1'b1;
    M_WEN     = 1'b1;
    M_ADDR    = '0;
    M_BE      = '0;
    M_DI      = '0;
    w_rsp_nxt = RSP_NONE;
    if (w_gnt_d) begin
      M_CSN     = 1'b0;
      M_WEN     = ~D_WE;
      M_ADDR    = D_ADDR;
      M_BE      = D_BE;
      M_DI      = D_WDATA;
      w_rsp_nxt = D_WE ? RSP_D_WR : RSP_D_RD;
    end else if (w_gnt_i) begin
      M_CSN     = 1'b0;
      M_ADDR    = I_ADDR;
      M_BE      = {BEW{1'b1}};
      w_rsp_nxt = RSP_I_RD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rsp <= RSP_NONE;
      r_ptr <= REQ_D;
    end else begin
      r_rsp <= w_rsp_nxt;
      if (w_gnt_i | w_gnt_d)
        r_ptr <= w_gnt_d ? REQ_I : REQ_D;
    end
  end

  // Responses are masked while RST is high so an in-flight access is dropped.
  assign I_RVALID = ~RST & (r_rsp == RSP_I_RD);
  assign D_RVALID = ~RST & ((r_rsp == RSP_D_RD) | (r_rsp == RSP_D_WR));
  assign I_RDATA  = I_RVALID ? M_DOUT : '0;
  assign D_RDATA  = (D_RVALID && r_rsp == RSP_D_RD) ? M_DOUT : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a response scoreboard.
module tb_sram_port_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic        I_REQ, D_REQ, D_WE;
  logic [11:0] I_ADDR, D_ADDR, M_ADDR;
  logic [3:0]  D_BE, M_BE;
  logic [31:0] D_WDATA, I_RDATA, D_RDATA, M_DI;
  logic [31:0] M_DOUT = '0;
  logic        I_GNT, I_RVALID, D_GNT, D_RVALID, M_CSN, M_WEN;

  typedef struct {
    logic [1:0]  kind;   // 0 none, 1 I read, 2 D read, 3 D write ack
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  int          n_asserts = 0;
  int          n_fail    = 0;

  always #5 CLK = ~CLK;

  sram_port_arbiter dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_CSN(M_CSN), .M_WEN(M_WEN), .M_ADDR(M_ADDR), .M_BE(M_BE), .M_DI(M_DI), .M_DOUT(M_DOUT)
  );

  // Single-port SRAM: write lands at the issue edge, read data registered.
  always @(posedge CLK) begin
    if (!M_CSN) begin
      if (!M_WEN) begin
        for (int b = 0; b < 4; b++)
          if (M_BE[b]) mem[M_ADDR][8*b +: 8] = M_DI[8*b +: 8];
      end else begin
        M_DOUT <= mem[M_ADDR];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check the previous cycle's response, check this cycle's
  // grant/pins against the expected winner, push its response, advance.
  task automatic cycle(input bit ei, input bit ed);
    exp_t p;
    #1;
    if (sb.size() == 0) p = '{2'd0, 32'h0};
    else                p = sb.pop_front();
    if (RST) p = '{2'd0, 32'h0};
    chk("I_RVALID", I_RVALID, p.kind == 2'd1);
    chk("I_RDATA",  I_RDATA,  (p.kind == 2'd1) ? p.data : 32'h0);
    chk("D_RVALID", D_RVALID, p.kind >= 2'd2);
    chk("D_RDATA",  D_RDATA,  (p.kind == 2'd2) ? p.data : 32'h0);
    chk("I_GNT", I_GNT, ei);
    chk("D_GNT", D_GNT, ed);
    chk("M_CSN", M_CSN, !(ei || ed));
    if (ed) begin
      chk("M_ADDR_D", M_ADDR, D_ADDR);
      chk("M_WEN_D",  M_WEN,  !D_WE);
      if (D_WE) begin
        chk("M_DI", M_DI, D_WDATA);
        for (int b = 0; b < 4; b++)
          if (D_BE[b]) ref_mem[D_ADDR][8*b +: 8] = D_WDATA[8*b +: 8];
        sb.push_back('{2'd3, 32'h0});
      end else begin
        sb.push_back('{2'd2, ref_mem[D_ADDR]});
      end
    end else if (ei) begin
      chk("M_ADDR_I", M_ADDR, I_ADDR);
      chk("M_BE_I",   M_BE,   4'hF);
      chk("M_WEN_I",  M_WEN,  1'b1);
      sb.push_back('{2'd1, ref_mem[I_ADDR]});
    end else begin
      chk("M_ADDR_IDLE", M_ADDR, 12'h0);
      sb.push_back('{2'd0, 32'h0});
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int mism;
    for (int a = 0; a < 4096; a++) begin
      mem[a]     = 32'h1000_0000 + a * 32'h0101;
      ref_mem[a] = mem[a];
    end
    mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    mem[9] = 32'hAABBCCDD; ref_mem[9] = 32'hAABBCCDD;

    RST = 1'b1; I_REQ = 0; D_REQ = 0; D_WE = 0; D_BE = 0;
    I_ADDR = 0; D_ADDR = 0; D_WDATA = 0;
    cycle(0, 0);
    cycle(0, 0);
    RST = 1'b0;
    cycle(0, 0);

    // Partial write then read-back on consecutive grants.
    D_REQ = 1; D_WE = 1; D_BE = 4'b0101; D_ADDR = 9; D_WDATA = 32'h11223344;
    cycle(0, 1);
    D_WE = 0;
    cycle(0, 1);
    D_REQ = 0;
    cycle(0, 0);
    chk("MEM9", mem[9], 32'hAA22CC44);

    // Back-to-back reads.
    D_REQ = 1; D_ADDR = 1; cycle(0, 1);
    D_ADDR = 2; cycle(0, 1);
    D_ADDR = 3; cycle(0, 1);
    D_REQ = 0; cycle(0, 0);

    // Write with no byte enables leaves memory untouched but is acked.
    D_REQ = 1; D_WE = 1; D_BE = 4'b0000; D_ADDR = 4; D_WDATA = 32'hFFFF_FFFF;
    cycle(0, 1);
    D_WE = 0;
    cycle(0, 1);
    D_REQ = 0;
    cycle(0, 0);

    // Instruction fetch; leaves the round-robin pointer preferring D.
    I_REQ = 1; I_ADDR = 5;
    cycle(1, 0);
    I_REQ = 0;
    cycle(0, 0);

    // Contention for 4 cycles.
    I_REQ = 1; I_ADDR = 7; D_REQ = 1; D_WE = 0; D_ADDR = 3;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      cycle(k % 2 == 1, k % 2 == 0);
`else
      cycle(0, 1);
`endif
    end
    I_REQ = 0; D_REQ = 0;
    cycle(0, 0);

    // Reset in the cycle after an I grant drops the response.
    I_REQ = 1; I_ADDR = 5;
    cycle(1, 0);
    RST = 1; D_REQ = 1; D_WE = 1; D_BE = 4'hF; D_ADDR = 6; D_WDATA = 32'h0;
    cycle(0, 0);
    cycle(0, 0);
    RST = 0; D_REQ = 0; D_WE = 0;
    cycle(1, 0);
    I_REQ = 0;
    cycle(0, 0);

    // Idle: no access, memory unchanged.
    cycle(0, 0);
    cycle(0, 0);
    cycle(0, 0);
    mism = 0;
    for (int a = 0; a < 64; a++)
      if (mem[a] !== ref_mem[a]) mism++;
    chk("MEM_CONTENTS", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
